// File: rtl/alu_result_tx.sv
// UART 8N1 transmitter for the ALU result byte: a rising edge on the push-button
// input captures `result` and shifts it out LSB first on `tx`.
module alu_result_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       mclk,
  input  logic       rst_n,
  input  logic [7:0] result,
  input  logic       send,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            tx_n, busy_n, done_n;
  logic            s1, s2, s3;
  logic            req;
  logic            bit_end;

  // Synchroniser flops reset high so a button held through reset release
  // never looks like a fresh press.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop take its neighbour's
      // pre-edge value; blocking ones would collapse the chain into one flop.
      s1 <= send;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign req     = s2 & ~s3;
  assign bit_end = (cnt == LAST);

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      // NOTE: the shift register is cleared on reset as well, so an abandoned
      // frame leaves no stale byte behind.
      shreg <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      tx    <= tx_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Outputs are registered from the next-state view, so tx/busy/done change on
  // the same edge as the state they describe.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    tx_n    = 1'b1;
    busy_n  = 1'b1;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (req) begin
          state_n = START;
          shreg_n = result;
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end

      START: begin
        tx_n = 1'b0;
        if (bit_end) begin
          state_n = DATA;
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = shreg[0];
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      DATA: begin
        tx_n = shreg[idx];
        if (bit_end) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            idx_n = idx + 3'd1;
            tx_n  = shreg[idx + 3'd1];
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          cnt_n   = '0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
